// File: rtl/aes_mixcol_if.sv
// Handshake bundle between an AES round datapath producer/consumer and the MixColumns engine.
// The driving side uses the master modport; the engine uses the slave modport.
interface aes_mixcol_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_inv, in_bypass, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_inv, in_bypass, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_mixcol_engine.sv
// Column-serial AES MixColumns / InvMixColumns engine with bypass.
// COLS_PER_CYCLE columns of the latched state are transformed per BUSY beat.
module aes_mixcol_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  aes_mixcol_if.slave  bus,
  output logic         busy
);

  localparam int         BEATS     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  generate
    if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4))) begin : g_bad_cols
      $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] data_q, data_d;
  logic [127:0] res_q, res_d;
  logic         inv_q, inv_d;
  logic         byp_q, byp_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficients never exceed 4'he, so four doubling steps cover every product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = p ^ (k[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Each matrix row is the previous one rotated right, so row r uses coef[(j-r) mod 4].
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv, input logic byp);
    logic [15:0] coef;
    logic [31:0] res;
    logic [7:0]  acc;
    coef = inv ? 16'hebd9 : 16'h2311;
    res  = 32'h0000_0000;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gmul(col[31-8*j -: 8], coef[15-4*((j-r+4)%4) -: 4]);
      end
      res[31-8*r -: 8] = acc;
    end
    return byp ? col : res;
  endfunction

  // Next-state logic: accept in IDLE, transform one slice per BUSY beat, hold in DONE.
  always_comb begin
    int idx;
    idx     = 0;
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    inv_d   = inv_q;
    byp_d   = byp_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_state;
          inv_d   = bus.in_inv;
          byp_d   = bus.in_bypass;
          beat_d  = 2'd0;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          idx = int'(beat_q) * COLS_PER_CYCLE + k;
          res_d[127-32*idx -: 32] = mix_col(data_q[127-32*idx -: 32], inv_q, byp_q);
        end
        if (beat_q == LAST_BEAT) begin
          beat_d  = 2'd0;
          state_d = S_DONE;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        beat_d  = 2'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      data_q  <= 128'd0;
      res_q   <= 128'd0;
      inv_q   <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      byp_q   <= byp_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_state = res_q;
  assign busy          = (state_q == S_BUSY) || (state_q == S_DONE);

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Scoreboard bench for aes_mixcol_engine with one instance per COLS_PER_CYCLE in {1,2,4}.
// Instance index sel maps to COLS_PER_CYCLE = 1<<sel and BEATS = 4>>sel.
module tb_aes_mixcol_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   vld, ordy;
  logic [127:0] st;
  logic         inv, byp;
  logic [2:0]   rdy_o, ovld_o, busy_o;
  logic [127:0] ost [3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [127:0] sb [$];

  localparam logic [127:0] KIN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] KOUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mixcol_if ifc ();
    assign ifc.in_valid  = vld[g];
    assign ifc.in_state  = st;
    assign ifc.in_inv    = inv;
    assign ifc.in_bypass = byp;
    assign ifc.out_ready = ordy[g];
    assign rdy_o[g]      = ifc.in_ready;
    assign ovld_o[g]     = ifc.out_valid;
    assign ost[g]        = ifc.out_state;
    aes_mixcol_engine #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc),
      .busy  (busy_o[g])
    );
  end

  // Reference GF(2^8) multiply: carry-less product, then reduce by 0x11b.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c, input logic i);
    logic [7:0]  co [4];
    logic [7:0]  x;
    logic [31:0] r;
    if (i) begin co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09; end
    else   begin co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01; end
    r = 32'h0;
    for (int rr = 0; rr < 4; rr++) begin
      x = 8'h00;
      for (int j = 0; j < 4; j++) x = x ^ gm(c[31-8*j -: 8], co[(j - rr + 4) % 4]);
      r[31-8*rr -: 8] = x;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s, input logic i, input logic b);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = ref_col(s[127-32*c -: 32], i);
    return b ? s : r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete transaction; called and returns at a sample point (#1 after posedge).
  task automatic run_block(input int sel, input logic [127:0] s, input logic i, input logic b,
                           input logic [127:0] exp_s, input int stall, output logic [127:0] got);
    int n;
    int lat;
    logic [127:0] e;
    got = 128'd0;
    sb.push_back(exp_s);
    st = s; inv = i; byp = b; vld[sel] = 1'b1; ordy[sel] = 1'b0;
    n = 0;
    while (rdy_o[sel] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (rdy_o[sel] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout sel=%0d in_ready=%b want 1", sel, rdy_o[sel]);
      vld[sel] = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk); #1;
    vld[sel] = 1'b0; st = rand128(); inv = ~i; byp = 1'($urandom_range(0, 1));
    checks++;
    if (busy_o[sel] !== 1'b1) begin errors++; $display("FAIL busy sel=%0d got=%b want 1", sel, busy_o[sel]); end
    lat = 0;
    while (ovld_o[sel] !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != (4 >> sel)) begin errors++; $display("FAIL latency sel=%0d got=%0d want=%0d", sel, lat, 4 >> sel); end
    repeat (stall) begin @(posedge clk); #1; end
    ordy[sel] = 1'b1;
    got = ost[sel];
    e = sb.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL data sel=%0d got=%h want=%h", sel, got, e); end
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    checks++;
    if (ovld_o[sel] !== 1'b0) begin errors++; $display("FAIL out_valid_drop sel=%0d got=%b want 0", sel, ovld_o[sel]); end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      checks += 4;
      if (rdy_o[g] !== 1'b1)    begin errors++; $display("FAIL rst_in_ready sel=%0d got=%b want 1", g, rdy_o[g]); end
      if (ovld_o[g] !== 1'b0)   begin errors++; $display("FAIL rst_out_valid sel=%0d got=%b want 0", g, ovld_o[g]); end
      if (ost[g] !== 128'd0)    begin errors++; $display("FAIL rst_out_state sel=%0d got=%h want 0", g, ost[g]); end
      if (busy_o[g] !== 1'b0)   begin errors++; $display("FAIL rst_busy sel=%0d got=%b want 0", g, busy_o[g]); end
    end
  endtask

  task automatic test_known_vectors(input int sel);
    logic [127:0] y;
    logic [127:0] r;
    run_block(sel, KIN, 1'b0, 1'b0, KOUT, 0, y);
    run_block(sel, KOUT, 1'b1, 1'b0, KIN, 1, y);
    run_block(sel, {4{32'hdb135345}}, 1'b0, 1'b0, {4{32'h8e4da1bc}}, 0, y);
    run_block(sel, {4{32'h8e4da1bc}}, 1'b1, 1'b0, {4{32'hdb135345}}, 0, y);
    run_block(sel, {4{32'hc6c6c6c6}}, 1'b0, 1'b0, {4{32'hc6c6c6c6}}, 0, y);
    run_block(sel, {4{32'hf20a225c}}, 1'b0, 1'b0, {4{32'h9fdc589d}}, 2, y);
    r = rand128();
    run_block(sel, r, 1'b1, 1'b1, r, 0, y);
    r = rand128();
    run_block(sel, r, 1'b0, 1'b1, r, 3, y);
  endtask

  task automatic test_backpressure(input int sel);
    logic [127:0] s;
    logic [127:0] e;
    int n;
    s = rand128();
    e = ref_state(s, 1'b0, 1'b0);
    sb.push_back(e);
    st = s; inv = 1'b0; byp = 1'b0; vld[sel] = 1'b1; ordy[sel] = 1'b0;
    n = 0;
    while (rdy_o[sel] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    vld[sel] = 1'b0;
    n = 0;
    while (ovld_o[sel] !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      checks += 3;
      if (ovld_o[sel] !== 1'b1) begin errors++; $display("FAIL bp_out_valid sel=%0d cyc=%0d got=%b want 1", sel, c, ovld_o[sel]); end
      if (ost[sel] !== e)       begin errors++; $display("FAIL bp_out_state sel=%0d cyc=%0d got=%h want=%h", sel, c, ost[sel], e); end
      if (rdy_o[sel] !== 1'b0)  begin errors++; $display("FAIL bp_in_ready sel=%0d cyc=%0d got=%b want 0", sel, c, rdy_o[sel]); end
      vld[sel] = 1'b1; st = rand128(); inv = 1'b1; byp = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    vld[sel] = 1'b0; ordy[sel] = 1'b1;
    checks++;
    if (ost[sel] !== sb[0]) begin errors++; $display("FAIL bp_release sel=%0d got=%h want=%h", sel, ost[sel], sb[0]); end
    void'(sb.pop_front());
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    checks++;
    if (busy_o[sel] !== 1'b0) begin errors++; $display("FAIL bp_idle sel=%0d busy=%b want 0", sel, busy_o[sel]); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] y;
    int n;
    st = KIN; inv = 1'b0; byp = 1'b0; vld[0] = 1'b1; ordy[0] = 1'b0;
    n = 0;
    while (rdy_o[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks += 4;
    if (rdy_o[0] !== 1'b1)  begin errors++; $display("FAIL mid_rst_in_ready got=%b want 1", rdy_o[0]); end
    if (ovld_o[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b want 0", ovld_o[0]); end
    if (ost[0] !== 128'd0)  begin errors++; $display("FAIL mid_rst_out_state got=%h want 0", ost[0]); end
    if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b want 0", busy_o[0]); end
    sb.delete();
    run_block(0, KIN, 1'b0, 1'b0, KOUT, 0, y);
  endtask

  task automatic test_back_to_back(input int sel);
    int acc [5];
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          logic [127:0] s;
          logic i, b;
          int n;
          s = rand128(); i = 1'($urandom_range(0, 1)); b = 1'b0;
          st = s; inv = i; byp = b; vld[sel] = 1'b1;
          n = 0;
          while (rdy_o[sel] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
          sb.push_back(ref_state(s, i, b));
          @(posedge clk); #1;
          acc[k] = cyc;
        end
        vld[sel] = 1'b0;
      end
      begin
        int got_n;
        int n;
        ordy[sel] = 1'b1;
        got_n = 0; n = 0;
        while (got_n < 5 && n < 200) begin
          if (ovld_o[sel] === 1'b1 && sb.size() > 0) begin
            logic [127:0] e;
            e = sb.pop_front();
            checks++;
            if (ost[sel] !== e) begin errors++; $display("FAIL b2b_data sel=%0d got=%h want=%h", sel, ost[sel], e); end
            got_n++;
          end
          @(posedge clk); #1;
          n++;
        end
        ordy[sel] = 1'b0;
        checks++;
        if (got_n != 5) begin errors++; $display("FAIL b2b_count sel=%0d got=%0d want 5", sel, got_n); end
      end
    join
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (acc[k] - acc[k-1] != (4 >> sel) + 2) begin
        errors++;
        $display("FAIL b2b_interval sel=%0d got=%0d want=%0d", sel, acc[k] - acc[k-1], (4 >> sel) + 2);
      end
    end
    sb.delete();
  endtask

  task automatic test_random(input int sel);
    logic [127:0] x, y, z;
    logic i, b;
    int m;
    for (int it = 0; it < 1000; it++) begin
      x = rand128();
      m = int'($urandom_range(0, 2));
      i = (m == 1);
      b = (m == 2);
      run_block(sel, x, i, b, ref_state(x, i, b), int'($urandom_range(0, 3)), y);
      if (m == 0) run_block(sel, y, 1'b1, 1'b0, x, int'($urandom_range(0, 3)), z);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; vld = 3'b000; ordy = 3'b000; st = 128'd0; inv = 1'b0; byp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) test_known_vectors(s);
    for (int s = 0; s < 3; s++) test_backpressure(s);
    test_reset_mid();
    for (int s = 0; s < 3; s++) test_back_to_back(s);
    for (int s = 0; s < 3; s++) test_random(s);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
